// File: rtl/spi_slave_pkg.sv
// Shared constants and mode encoding for the SPI slave.
package spi_slave_pkg;

  localparam int unsigned WIDTH_MIN = 4;
  localparam int unsigned WIDTH_MAX = 32;

  // SPI mode = {CPOL, CPHA}
  typedef enum logic [1:0] {
    MODE_0 = 2'b00,
    MODE_1 = 2'b01,
    MODE_2 = 2'b10,
    MODE_3 = 2'b11
  } spi_mode_e;

  typedef enum logic [1:0] {
    ST_RESYNC = 2'b00,
    ST_IDLE   = 2'b01,
    ST_ACTIVE = 2'b10
  } spi_state_e;

  // Data is sampled on rising SCK when CPOL == CPHA, otherwise on falling SCK.
  function automatic logic sample_on_rise(input spi_mode_e mode);
    return mode[1] == mode[0];
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// N-flop synchroniser with rise/fall detection taken from the two oldest stages.
module spi_sync_edge #(
  parameter int unsigned N       = 3,
  parameter logic        RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic level,
  output logic rise_c,
  output logic fall_c
);

  logic [N-1:0] sync_q;

  // Shift the asynchronous input through the synchroniser chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= {N{RST_VAL}};
    else        sync_q <= {sync_q[N-2:0], din};
  end

  assign level  = sync_q[N-1];
  assign rise_c =  sync_q[N-2] & ~sync_q[N-1];
  assign fall_c = ~sync_q[N-2] &  sync_q[N-1];

endmodule

// File: rtl/spi_slave_param.sv
// Parameterised SPI slave (all four modes) with valid/ready RX and TX ports.
// Optional build macro SPI_SLAVE_ECHO_EN: on TX underrun the last received
// word is echoed back instead of zeros.
module spi_slave_param
  import spi_slave_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter logic        CPOL  = 1'b0,
  parameter logic        CPHA  = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             SCK,
  input  logic             SSEL,
  input  logic             MOSI,
  output logic             MISO,
  output logic             miso_oe,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid,
  input  logic             rx_ready,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             tx_valid,
  output logic             tx_ready,
  output logic             rx_overrun,
  output logic             tx_underrun,
  output logic             frame_err,
  output logic             msg_start,
  output logic             msg_end
);

  localparam int unsigned CNT_W       = $clog2(WIDTH);
  localparam int unsigned SYNC_N      = 3;
  localparam int unsigned FLUSH_W     = 2;
  localparam logic [CNT_W-1:0]   CNT_LAST   = CNT_W'(WIDTH - 1);
  localparam logic [FLUSH_W-1:0] FLUSH_LAST = FLUSH_W'(SYNC_N);
  localparam spi_mode_e  MODE        = spi_mode_e'({CPOL, CPHA});
  localparam logic       SAMPLE_RISE = sample_on_rise(MODE);

  if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_bad_width
    $error("spi_slave_param: WIDTH outside supported range");
  end

  spi_state_e         state_q, state_d;
  logic [FLUSH_W-1:0] flush_q;
  logic [CNT_W-1:0]   bit_cnt_q;
  logic [1:0]         mosi_q;
  logic [WIDTH-2:0]   rx_sh_q;
  logic [WIDTH-1:0]   tx_sh_q;
  logic [WIDTH-1:0]   tx_hold_q;

  logic sck_lvl, sck_rise_c, sck_fall_c;
  logic ssel_lvl, ssel_rise_c, ssel_fall_c;
  logic start_c, end_c, active_c;
  logic sample_c, shift_c, word_done_c, load_c;
  logic [WIDTH-1:0] rx_word_c;
  logic [WIDTH-1:0] underrun_word_c;

  spi_sync_edge #(.N(SYNC_N), .RST_VAL(CPOL)) u_sck_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .din    (SCK),
    .level  (sck_lvl),
    .rise_c (sck_rise_c),
    .fall_c (sck_fall_c)
  );

  spi_sync_edge #(.N(SYNC_N), .RST_VAL(1'b1)) u_ssel_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .din    (SSEL),
    .level  (ssel_lvl),
    .rise_c (ssel_rise_c),
    .fall_c (ssel_fall_c)
  );

  // State register; RESYNC flushes the synchronisers so a select held low across reset is not taken as a new message.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_RESYNC;
      flush_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_RESYNC && flush_q != FLUSH_LAST) flush_q <= flush_q + FLUSH_W'(1);
    end
  end

  // Next state and message start/end events.
  always_comb begin
    state_d = state_q;
    start_c = 1'b0;
    end_c   = 1'b0;
    unique case (state_q)
      ST_RESYNC: if (flush_q == FLUSH_LAST && ssel_lvl && sck_lvl == CPOL) state_d = ST_IDLE;
      ST_IDLE: begin
        if (ssel_fall_c) begin
          state_d = ST_ACTIVE;
          start_c = 1'b1;
        end
      end
      ST_ACTIVE: begin
        if (ssel_rise_c) begin
          state_d = ST_IDLE;
          end_c   = 1'b1;
        end
      end
      default: state_d = ST_RESYNC;
    endcase
  end

  assign active_c    = (state_q == ST_ACTIVE);
  assign sample_c    = active_c & (SAMPLE_RISE ? sck_rise_c : sck_fall_c);
  assign shift_c     = active_c & (SAMPLE_RISE ? sck_fall_c : sck_rise_c);
  assign word_done_c = sample_c & (bit_cnt_q == CNT_LAST);
  assign rx_word_c   = {rx_sh_q, mosi_q[1]};
  assign load_c      = ((!CPHA) && start_c) || (shift_c && (bit_cnt_q == '0));

`ifdef SPI_SLAVE_ECHO_EN
  assign underrun_word_c = rx_data;
`else
  assign underrun_word_c = '0;
`endif

  assign MISO = tx_sh_q[WIDTH-1];

  // MOSI synchroniser, two stages to line up with the SCK edge detect.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) mosi_q <= '0;
    else        mosi_q <= {mosi_q[0], MOSI};
  end

  // Bit counter: held at zero outside a message, wraps at the word boundary.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                   bit_cnt_q <= '0;
    else if (!active_c)           bit_cnt_q <= '0;
    else if (sample_c)            bit_cnt_q <= (bit_cnt_q == CNT_LAST) ? '0 : bit_cnt_q + CNT_W'(1);
  end

  // Receive shift register and RX output handshake with overrun detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_sh_q    <= '0;
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      rx_overrun <= 1'b0;
    end else begin
      rx_overrun <= 1'b0;
      if (!active_c)     rx_sh_q <= '0;
      else if (sample_c) rx_sh_q <= rx_word_c[WIDTH-2:0];
      if (word_done_c) begin
        rx_data    <= rx_word_c;
        rx_valid   <= 1'b1;
        rx_overrun <= rx_valid & ~rx_ready;
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

  // Transmit holding and shift registers; an empty holding register at a load point underruns.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_sh_q     <= '0;
      tx_hold_q   <= '0;
      tx_ready    <= 1'b1;
      tx_underrun <= 1'b0;
    end else begin
      tx_underrun <= 1'b0;
      if (load_c) begin
        if (!tx_ready) begin
          tx_sh_q  <= tx_hold_q;
          tx_ready <= 1'b1;
        end else begin
          tx_sh_q     <= underrun_word_c;
          tx_underrun <= 1'b1;
          if (tx_valid) begin
            tx_hold_q <= tx_data;
            tx_ready  <= 1'b0;
          end
        end
      end else begin
        if (shift_c) tx_sh_q <= {tx_sh_q[WIDTH-2:0], 1'b0};
        if (tx_valid && tx_ready) begin
          tx_hold_q <= tx_data;
          tx_ready  <= 1'b0;
        end
      end
    end
  end

  // Registered status pulses and output enable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      msg_start <= 1'b0;
      msg_end   <= 1'b0;
      frame_err <= 1'b0;
      miso_oe   <= 1'b0;
    end else begin
      msg_start <= start_c;
      msg_end   <= end_c;
      frame_err <= end_c & (bit_cnt_q != '0);
      miso_oe   <= (state_d == ST_ACTIVE);
    end
  end

endmodule

// File: doc/spi_slave_param.md
SPI_SLAVE_PARAM -- requirements
Module: spi_slave_param

Interface
REQ-001 Parameter WIDTH, default 8, SPI word length in bits; legal range 4..32.
REQ-002 Parameter CPOL, default 0, SCK idle level.
REQ-003 Parameter CPHA, default 0, SPI clock phase (0: sample on leading edge; 1: sample on trailing edge).
REQ-004 clk  in  1  system clock; all logic on rising edge.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 SCK  in  1  SPI clock, asynchronous to clk.
REQ-007 SSEL  in  1  slave select, active low, asynchronous.
REQ-008 MOSI  in  1  serial data in, MSB first.
REQ-009 MISO  out  1  serial data out, MSB first.
REQ-010 miso_oe  out  1  high while SSEL is active (synchronised); used for external tri-state.
REQ-011 rx_data  out  WIDTH  last complete received word.
REQ-012 rx_valid  out  1  rx_data holds an unread word.
REQ-013 rx_ready  in  1  consumer accepts rx_data when rx_valid & rx_ready.
REQ-014 tx_data  in  WIDTH  next word to transmit.
REQ-015 tx_valid  in  1  tx_data offered.
REQ-016 tx_ready  out  1  TX holding register empty; load on tx_valid & tx_ready.
REQ-017 rx_overrun, tx_underrun, frame_err, msg_start, msg_end  out  1 each  single-cycle status pulses.

Function
REQ-018 SCK and SSEL synchronised through 3 flops; MOSI through 2 flops; edges detected from the two oldest stages.
REQ-019 Sample edge: rising SCK when CPOL==CPHA, otherwise falling; shift edge is the opposite SCK edge.
REQ-020 Bit counter of $clog2(WIDTH) bits; cleared while SSEL is inactive; increments on each sample edge; wraps from WIDTH-1 to 0.
REQ-021 On the sample edge of bit WIDTH-1, the completed word is written to rx_data one clk later, and rx_valid is set in the same cycle.
REQ-022 If rx_valid & ~rx_ready at word completion: rx_data is overwritten, rx_valid stays 1, and rx_overrun pulses.
REQ-023 rx_valid clears on rx_valid & rx_ready unless a new word completes in the same cycle; in that case rx_valid stays 1 with the new data.
REQ-024 TX shift register load point for CPHA=0: at msg_start and on the shift edge following bit WIDTH-1.
REQ-025 TX shift register load point for CPHA=1: on the first shift edge of each word (bit counter == 0).
REQ-026 At the load point, if the holding register is full, it is copied to the shift register and tx_ready rises the next clk.
REQ-027 At the load point, if the holding register is empty, the underrun word is loaded (see REQ-037) and tx_underrun pulses.
REQ-028 Simultaneous load point and tx_valid & tx_ready: the shift register takes the underrun word; the new word goes to the holding register.
REQ-029 On all other shift edges the shift register shifts left with 0 in; MISO = shift register MSB.
REQ-030 msg_start pulses on the synchronised SSEL falling edge.
REQ-031 msg_end pulses on the synchronised SSEL rising edge.
REQ-032 frame_err pulses with msg_end if the bit counter != 0; the partial word is discarded and rx_valid is unaffected.

Reset
REQ-033 rst_n low: all synchroniser flops set to idle (SCK=CPOL, SSEL=1).
REQ-034 rst_n low: bit counter 0; shift and holding registers 0; rx_data 0.
REQ-035 rst_n low: rx_valid 0, tx_ready 1, MISO 0, miso_oe 0, all status pulses 0.
REQ-036 Reset mid-message: the block returns to idle immediately; after release it waits for a fresh SSEL falling edge before receiving.

Configuration
REQ-037 SPI_SLAVE_ECHO_EN defined: the underrun word is the last completed rx word. Undefined: the underrun word is all zeros.

Structure
REQ-038 Package spi_slave_pkg holds the WIDTH bounds constants and the mode encoding (mode = {CPOL,CPHA}).
REQ-039 Sub-module spi_sync_edge (N-flop synchroniser plus rise/fall detection) is instantiated for SCK and SSEL.

Verification
REQ-040 Mode 0, WIDTH=8, tx 0xA5 preloaded, master sends 0x3C -> MISO carries 0xA5; rx_data=0x3C and rx_valid 1 clk after the 8th rising SCK.
REQ-041 Modes 1/2/3, WIDTH=16, tx 0x1234, master sends 0xBEEF -> exchange is correct in each mode.
REQ-042 Two words sent with rx_ready=0 -> rx_overrun pulses once; rx_data holds the second word.
REQ-043 No tx word loaded, second word of a message after rx 0x55 -> tx_underrun pulses; MISO sends 0x55 with ECHO_EN, 0x00 without.
REQ-044 SSEL raised after 5 bits -> frame_err and msg_end pulse together; no rx_valid; the next message aligns on bit 0.
REQ-045 rst_n asserted mid-word -> all outputs reach their reset values asynchronously; the following full message is received correctly.
